score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 22 ++
 rtl/score_keeper.sv | 133 +++++++++++++
 tb/tb_score_keeper.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Judge/miss inputs and score/BCD outputs of the score keeper, grouped as one bus.
interface score_keeper_if;
    logic        clear;
    logic        judge_valid;
    logic [1:0]  score;
    logic        miss;
    logic [13:0] total;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [15:0] bcd;
    logic        bcd_busy;

    modport master (
        output clear, judge_valid, score, miss,
        input  total, combo, max_combo, bcd, bcd_busy
    );

    modport slave (
        input  clear, judge_valid, score, miss,
        output total, combo, max_combo, bcd, bcd_busy
    );
endinterface

// File: rtl/score_keeper.sv
// Rhythm-game score accumulator with combo tracking and an iterative
// double-dabble converter that feeds a four-digit BCD display.
module score_keeper (
    input  logic           i_clk,
    input  logic           i_rst_n,
    score_keeper_if.slave  io_bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [13:0] MaxTotal = 14'd9999;

    logic [13:0] r_total;
    logic [7:0]  r_combo;
    logic [7:0]  r_max_combo;
    logic        r_chg;
    state_e      r_state;
    logic        r_pending;
    logic [13:0] r_bin;
    logic [15:0] r_work;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;

    logic [2:0]  w_base;
    logic [3:0]  w_pts;
    logic [14:0] w_sum;
    logic [13:0] w_total_nx;
    logic [7:0]  w_combo_nx;
    state_e      w_state_nx;
    logic        w_start;
    logic [15:0] w_adj;

    always_comb begin
        w_base = 3'd0;
        case (io_bus.score)
            2'b11:        w_base = 3'd3;
            2'b10, 2'b01: w_base = 3'd1;
            default:      w_base = 3'd0;
        endcase
        w_pts      = (r_combo >= 8'd10) ? {w_base, 1'b0} : {1'b0, w_base};
        w_sum      = {1'b0, r_total} + {11'd0, w_pts};
        w_total_nx = r_total;
        if (io_bus.judge_valid) begin
            w_total_nx = (w_sum > {1'b0, MaxTotal}) ? MaxTotal : w_sum[13:0];
        end
        // A miss in the same cycle as a hit still breaks the combo.
        w_combo_nx = r_combo;
        if (io_bus.miss || (io_bus.judge_valid && io_bus.score == 2'b00)) begin
            w_combo_nx = 8'd0;
        end else if (io_bus.judge_valid && r_combo != 8'd255) begin
            w_combo_nx = r_combo + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_chg       <= 1'b0;
        end else if (io_bus.clear) begin
            r_total     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_chg       <= 1'b0;
        end else begin
            r_total <= w_total_nx;
            r_combo <= w_combo_nx;
            if (w_combo_nx > r_max_combo) r_max_combo <= w_combo_nx;
            r_chg <= (w_total_nx != r_total);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_chg || r_pending) begin
                    w_state_nx = StShift;
                    w_start    = 1'b1;
                end
            end
            StShift: if (r_cnt == 4'd13) w_state_nx = StDone;
            StDone:  w_state_nx = StIdle;
            default: w_state_nx = StIdle;
        endcase
        w_adj = r_work;
        for (int i = 0; i < 4; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_pending <= 1'b0;
            r_bin     <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else if (io_bus.clear) begin
            r_state   <= StIdle;
            r_pending <= 1'b0;
            r_bin     <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                // r_total already holds the latest value, so a pending change is absorbed here.
                r_bin     <= r_total;
                r_work    <= '0;
                r_cnt     <= '0;
                r_pending <= 1'b0;
            end else if (r_chg && r_state != StIdle) begin
                r_pending <= 1'b1;
            end
            if (r_state == StShift) begin
                r_work <= {w_adj[14:0], r_bin[13]};
                r_bin  <= {r_bin[12:0], 1'b0};
                r_cnt  <= r_cnt + 4'd1;
            end
            if (r_state == StDone) r_bcd <= r_work;
        end
    end

    assign io_bus.total     = r_total;
    assign io_bus.combo     = r_combo;
    assign io_bus.max_combo = r_max_combo;
    assign io_bus.bcd       = r_bcd;
    assign io_bus.bcd_busy  = (r_state != StIdle);
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoring, combo, saturation, BCD timing, clear and reset.
module tb_score_keeper;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    score_keeper_if bus ();

    score_keeper dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hit(input logic [1:0] sc, input logic m);
        bus.judge_valid = 1'b1;
        bus.score       = sc;
        bus.miss        = m;
        @(posedge clk);
        #1;
        bus.judge_valid = 1'b0;
        bus.score       = 2'b00;
        bus.miss        = 1'b0;
    endtask

    // Wait for three consecutive idle samples so a queued restart is not mistaken for idle.
    task automatic wait_idle();
        int zeros = 0;
        int n = 0;
        while (zeros < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            zeros = bus.bcd_busy ? 0 : zeros + 1;
        end
        chk("idle_timeout", 32'(zeros >= 3), 32'd1);
    endtask

    initial begin
        int n53;
        int n56;
        int highs;
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        bus.clear = 1'b0;
        bus.judge_valid = 1'b0;
        bus.score = 2'b00;
        bus.miss = 1'b0;
        #1;
        chk("rst_total", 32'(bus.total), 32'd0);
        chk("rst_combo", 32'(bus.combo), 32'd0);
        chk("rst_max", 32'(bus.max_combo), 32'd0);
        chk("rst_bcd", 32'(bus.bcd), 32'h0);
        chk("rst_busy", 32'(bus.bcd_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(bus.bcd_busy), 32'd0);

        // 12 perfect hits back to back: 10*3 + 2*6
        for (int i = 0; i < 12; i++) hit(2'b11, 1'b0);
        chk("s1_total", 32'(bus.total), 32'd42);
        chk("s1_combo", 32'(bus.combo), 32'd12);
        chk("s1_max", 32'(bus.max_combo), 32'd12);
        wait_idle();
        chk("s1_bcd", 32'(bus.bcd), 32'h0042);

        // score ignored without judge_valid
        bus.score = 2'b11;
        @(posedge clk);
        #1;
        bus.score = 2'b00;
        chk("ign_total", 32'(bus.total), 32'd42);
        chk("ign_combo", 32'(bus.combo), 32'd12);

        hit(2'b00, 1'b0);
        chk("s2_none_combo", 32'(bus.combo), 32'd0);
        chk("s2_none_total", 32'(bus.total), 32'd42);
        @(posedge clk);
        #1;
        chk("s2_none_noconv", 32'(bus.bcd_busy), 32'd0);
        hit(2'b01, 1'b0);
        chk("s2_early_combo", 32'(bus.combo), 32'd1);
        chk("s2_early_total", 32'(bus.total), 32'd43);
        chk("s2_max", 32'(bus.max_combo), 32'd12);

        for (int i = 0; i < 4; i++) hit(2'b10, 1'b0);
        chk("s4_pre_combo", 32'(bus.combo), 32'd5);
        chk("s4_pre_total", 32'(bus.total), 32'd47);
        hit(2'b11, 1'b1);
        chk("s4_total", 32'(bus.total), 32'd50);
        chk("s4_combo", 32'(bus.combo), 32'd0);
        wait_idle();
        chk("s4_bcd", 32'(bus.bcd), 32'h0050);

        // second hit 5 cycles into a conversion
        hit(2'b11, 1'b0);
        chk("s5_total1", 32'(bus.total), 32'd53);
        n53 = 0;
        n56 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                bus.judge_valid = 1'b1;
                bus.score = 2'b11;
            end else if (n == 6) begin
                bus.judge_valid = 1'b0;
                bus.score = 2'b00;
            end
            if (bus.bcd == 16'h0053 && n53 == 0) n53 = n;
            if (bus.bcd == 16'h0056 && n56 == 0) n56 = n;
        end
        chk("s5_total2", 32'(bus.total), 32'd56);
        chk("s5_old_first", 32'(n53 > 0 && n53 <= 16), 32'd1);
        chk("s5_new_later", 32'(n56 > n53 && n56 <= 32), 32'd1);

        // build to 9998 with combo >= 10
        for (int i = 0; i < 8; i++) hit(2'b11, 1'b0);
        chk("s3_80", 32'(bus.total), 32'd80);
        for (int i = 0; i < 1653; i++) hit(2'b11, 1'b0);
        chk("s3_9998", 32'(bus.total), 32'd9998);
        chk("s3_combo_sat", 32'(bus.combo), 32'd255);
        chk("s3_max_sat", 32'(bus.max_combo), 32'd255);
        wait_idle();
        hit(2'b11, 1'b0);
        chk("s3_9999", 32'(bus.total), 32'd9999);
        wait_idle();
        chk("s3_bcd", 32'(bus.bcd), 32'h9999);
        hit(2'b11, 1'b0);
        chk("s3_hold", 32'(bus.total), 32'd9999);
        highs = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.bcd_busy) highs++;
        end
        chk("s3_noconv", 32'(highs), 32'd0);

        // clear wins over a simultaneous hit
        bus.clear = 1'b1;
        bus.judge_valid = 1'b1;
        bus.score = 2'b11;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.judge_valid = 1'b0;
        bus.score = 2'b00;
        chk("clr_total", 32'(bus.total), 32'd0);
        chk("clr_combo", 32'(bus.combo), 32'd0);
        chk("clr_max", 32'(bus.max_combo), 32'd0);
        chk("clr_bcd", 32'(bus.bcd), 32'h0);
        chk("clr_busy", 32'(bus.bcd_busy), 32'd0);

        // async reset in the middle of SHIFT
        hit(2'b11, 1'b0);
        chk("rs_total", 32'(bus.total), 32'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("rs_busy_mid", 32'(bus.bcd_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_total0", 32'(bus.total), 32'd0);
        chk("rs_combo0", 32'(bus.combo), 32'd0);
        chk("rs_max0", 32'(bus.max_combo), 32'd0);
        chk("rs_bcd0", 32'(bus.bcd), 32'h0);
        chk("rs_busy0", 32'(bus.bcd_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        highs = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.bcd_busy) highs++;
        end
        chk("rs_nospur", 32'(highs), 32'd0);
        chk("rs_bcd_after", 32'(bus.bcd), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
